// File: rtl/lif_pkg.sv
// Shared widths, default tuning constants and the saturating adder used by the LIF neuron tile.
package lif_pkg;

  localparam int STATE_W = 8;
  localparam int CNT_W   = 7;

  localparam int THRESHOLD_DEF     = 200;
  localparam int LEAK_SHIFT_DEF    = 1;
  localparam int REFRAC_CYCLES_DEF = 2;

  // Bidirectional pad bank word: spike flag above the spike counter.
  typedef struct packed {
    logic             spike;
    logic [CNT_W-1:0] cnt;
  } lif_uio_t;

  // Clamp a one-bit-wider sum back into the membrane range.
  function automatic logic [STATE_W-1:0] sat_state(input logic [STATE_W:0] sum);
    logic [STATE_W-1:0] res;
    if (sum[STATE_W]) begin
      res = {STATE_W{1'b1}};
    end else begin
      res = sum[STATE_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/lif_core.sv
// Membrane potential, refractory timer, spike flag and spike counter of one LIF neuron.
module lif_core
  import lif_pkg::*;
#(
  parameter int THRESHOLD     = THRESHOLD_DEF,
  parameter int LEAK_SHIFT    = LEAK_SHIFT_DEF,
  parameter int REFRAC_CYCLES = REFRAC_CYCLES_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ena_i,
  input  logic [STATE_W-1:0] cur_i,
  output logic [STATE_W-1:0] state_o,
  output logic               spike_o,
  output logic [CNT_W-1:0]   spk_cnt_o
);

  localparam int REFRAC_W = (REFRAC_CYCLES < 2) ? 1 : $clog2(REFRAC_CYCLES + 1);
  localparam logic [STATE_W-1:0]  THR         = STATE_W'(THRESHOLD);
  localparam logic [REFRAC_W-1:0] REFRAC_INIT = REFRAC_W'(REFRAC_CYCLES);

  logic [STATE_W-1:0]  state_q, state_d;
  logic                spike_q, spike_d;
  logic [REFRAC_W-1:0] refrac_q, refrac_d;
  logic [CNT_W-1:0]    spk_cnt_q, spk_cnt_d;

  logic [STATE_W-1:0] leak_s;
  logic [STATE_W:0]   sum_s;

  assign leak_s = state_q >> LEAK_SHIFT;
  assign sum_s  = {1'b0, cur_i} + {1'b0, leak_s};

  // Fire has priority over refractory hold, which has priority over integration.
  always_comb begin
    state_d   = state_q;
    spike_d   = spike_q;
    refrac_d  = refrac_q;
    spk_cnt_d = spk_cnt_q;
    if (ena_i) begin
      if (state_q >= THR) begin
        spike_d   = 1'b1;
        state_d   = {STATE_W{1'b0}};
        refrac_d  = REFRAC_INIT;
        spk_cnt_d = spk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (refrac_q != {REFRAC_W{1'b0}}) begin
        spike_d  = 1'b0;
        state_d  = {STATE_W{1'b0}};
        refrac_d = refrac_q - {{(REFRAC_W-1){1'b0}}, 1'b1};
      end else begin
        spike_d = 1'b0;
        state_d = sat_state(sum_s);
      end
    end else begin
      state_d   = state_q;
      spike_d   = spike_q;
      refrac_d  = refrac_q;
      spk_cnt_d = spk_cnt_q;
    end
  end

  // Synchronous reset wins over the tile enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= {STATE_W{1'b0}};
      spike_q   <= 1'b0;
      refrac_q  <= {REFRAC_W{1'b0}};
      spk_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      spike_q   <= spike_d;
      refrac_q  <= refrac_d;
      spk_cnt_q <= spk_cnt_d;
    end
  end

  assign state_o   = state_q;
  assign spike_o   = spike_q;
  assign spk_cnt_o = spk_cnt_q;

  lif_core_chk #(
    .REFRAC_CYCLES (REFRAC_CYCLES),
    .REFRAC_W      (REFRAC_W)
  ) u_chk (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ena_i    (ena_i),
    .state_i  (state_q),
    .spike_i  (spike_q),
    .refrac_i (refrac_q)
  );

endmodule

// File: rtl/lif_core_chk.sv
// Invariant checker for the neuron core: spike/refractory states always carry a zero potential.
module lif_core_chk
  import lif_pkg::*;
#(
  parameter int REFRAC_CYCLES = REFRAC_CYCLES_DEF,
  parameter int REFRAC_W      = 2
) (
  input logic                clk_i,
  input logic                rst_i,
  input logic                ena_i,
  input logic [STATE_W-1:0]  state_i,
  input logic                spike_i,
  input logic [REFRAC_W-1:0] refrac_i
);

  localparam logic [REFRAC_W-1:0] REFRAC_MAX = REFRAC_W'(REFRAC_CYCLES);

  a_spike_clears_state: assert property (@(posedge clk_i) disable iff (rst_i)
    spike_i |-> (state_i == {STATE_W{1'b0}}));

  a_refrac_holds_zero: assert property (@(posedge clk_i) disable iff (rst_i)
    (refrac_i != {REFRAC_W{1'b0}}) |-> (state_i == {STATE_W{1'b0}}));

  a_refrac_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    refrac_i <= REFRAC_MAX);

  a_spike_one_cycle: assert property (@(posedge clk_i) disable iff (rst_i)
    (spike_i && ena_i) |=> !spike_i);

endmodule

// File: rtl/lif_neuron_mtchun.sv
// TinyTapeout tile top: maps the harness pads onto the LIF neuron core; all outputs are registers.
module lif_neuron_mtchun
  import lif_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [STATE_W-1:0] state_s;
  logic               spike_s;
  logic [CNT_W-1:0]   spk_cnt_s;
  lif_uio_t           uio_s;
  logic               unused_s;

  lif_core #(
    .THRESHOLD     (THRESHOLD_DEF),
    .LEAK_SHIFT    (LEAK_SHIFT_DEF),
    .REFRAC_CYCLES (REFRAC_CYCLES_DEF)
  ) u_core (
    .clk_i     (clk),
    .rst_i     (rst),
    .ena_i     (ena),
    .cur_i     (ui_in),
    .state_o   (state_s),
    .spike_o   (spike_s),
    .spk_cnt_o (spk_cnt_s)
  );

  assign uio_s.spike = spike_s;
  assign uio_s.cnt   = spk_cnt_s;

  assign uo_out  = state_s;
  assign uio_out = uio_s;
  assign uio_oe  = 8'hFF;

  // The bidirectional inputs are not used by the neuron.
  assign unused_s = &{1'b0, uio_in};

endmodule

// File: tb/tb_lif_neuron_mtchun.sv
// Self-checking bench for lif_neuron_mtchun: directed scenarios plus random stimulus vs. a behavioural model.
module tb_lif_neuron_mtchun;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  bit m_valid = 1'b0;
  int m_state = 0;
  int m_spike = 0;
  int m_refrac = 0;
  int m_cnt = 0;

  lif_neuron_mtchun dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input int u);
    int sum;
    if (r) begin
      m_state = 0; m_spike = 0; m_refrac = 0; m_cnt = 0;
      m_valid = 1'b1;
    end else if (e) begin
      if (m_state >= 200) begin
        m_spike = 1; m_state = 0; m_refrac = 2; m_cnt = (m_cnt + 1) % 128;
      end else if (m_refrac > 0) begin
        m_spike = 0; m_state = 0; m_refrac = m_refrac - 1;
      end else begin
        m_spike = 0;
        sum = u + m_state / 2;
        m_state = (sum > 255) ? 255 : sum;
      end
    end
  endtask

  // One clock edge with the given inputs; returns at the following falling edge.
  task automatic step(input bit r, input bit e, input int u);
    rst = r; ena = e; ui_in = 8'(u); uio_in = 8'($urandom);
    @(posedge clk);
    model_edge(r, e, u);
    @(negedge clk);
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_uo_out", int'(uo_out), m_state);
      check("model_uio_out", int'(uio_out), m_spike * 128 + m_cnt);
      check("model_uio_oe", int'(uio_oe), 255);
    end
  end

  int exp_lk [10] = '{100, 150, 175, 187, 193, 196, 198, 199, 199, 199};
  int exp_sp [10] = '{120, 180, 210, 0, 0, 0, 120, 180, 210, 0};
  int exp_uo [10] = '{0, 0, 0, 129, 1, 1, 1, 1, 1, 130};

  initial begin
    rst = 1'b1; ena = 1'b0; ui_in = 8'd0; uio_in = 8'd0;
    @(negedge clk);

    // 1. reset with ena low and a live input
    step(1'b1, 1'b0, 77);
    step(1'b1, 1'b0, 77);
    check("rst_uo_out", int'(uo_out), 0);
    check("rst_uio_out", int'(uio_out), 0);
    check("rst_uio_oe", int'(uio_oe), 8'hFF);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 0);
      check("zero_input", int'(uo_out), 0);
    end

    // 2. sub-threshold input converges at 199
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 100);
      check("leak_uo_out", int'(uo_out), exp_lk[i]);
      check("leak_no_spike", int'(uio_out[7]), 0);
    end

    // 3. periodic spiking with refractory gap
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 120);
      check("spike_uo_out", int'(uo_out), exp_sp[i]);
      check("spike_uio_out", int'(uio_out), exp_uo[i]);
    end

    // 4. saturation
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 120);
    step(1'b0, 1'b1, 120);
    check("sat_pre", int'(uo_out), 180);
    step(1'b0, 1'b1, 255);
    check("sat_clamp", int'(uo_out), 255);
    step(1'b0, 1'b1, 255);
    check("sat_spike_state", int'(uo_out), 0);
    check("sat_spike_flag", int'(uio_out), 8'h81);

    // 5. enable low freezes everything
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 120);
    step(1'b0, 1'b1, 120);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 120);
      check("frozen_uo_out", int'(uo_out), 180);
      check("frozen_uio_out", int'(uio_out), 0);
    end
    step(1'b0, 1'b1, 120);
    check("resume", int'(uo_out), 210);

    // 6. reset during refractory, then counter wrap
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 120);
    check("pre_rst_spike", int'(uio_out), 8'h81);
    step(1'b0, 1'b1, 120);
    step(1'b1, 1'b1, 120);
    check("midrst_uo_out", int'(uo_out), 0);
    check("midrst_uio_out", int'(uio_out), 0);
    step(1'b0, 1'b1, 50);
    check("refrac_cleared", int'(uo_out), 50);

    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 506; i++) step(1'b0, 1'b1, 255);
    check("cnt_127", int'(uio_out), 8'hFF);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 255);
    check("cnt_wrap", int'(uio_out), 8'h80);

    // 7. random traffic, checked by the continuous compare process
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), int'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
